sistema_ventilacao_seq: RTL and testbench
=========================================

Name: sistema_ventilacao_seq

Overview:
Clocked, parametrised successor to the combinational ventilation controller. Monitors a cascade of NUM_ZONAS pressure sensors plus the reactor-hall sensor and drives one damper per zone boundary. A persistence-filtered pressure-cascade check feeds a 4-state alarm FSM with operator acknowledge and forced isolation. Sits between the sensor front-end and the damper actuator/alarm drivers.

Parameters:
NUM_ZONAS, 4, number of zones in cascade order; zone 0 is the cleanest, zone NUM_ZONAS-1 is adjacent to the reactor (minimum 2).
LARG_PRES, 4, pressure sample width in bits, unsigned.
DIF_MIN, 1, minimum required differential pres[i]-pres[i+1] for a healthy boundary.
PERSIST, 8, consecutive violating cycles before the alarm fires (minimum 1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
sens_pres  input  NUM_ZONAS*LARG_PRES  zone pressures; zone i occupies bits [i*LARG_PRES +: LARG_PRES].
sens_pres_rea  input  LARG_PRES  reactor-hall pressure; treated as boundary NUM_ZONAS-1 -> reactor.
reconhece  input  1  operator acknowledge pulse.
damper  output  NUM_ZONAS  damper[i]=1 opens boundary i -> i+1 (damper[NUM_ZONAS-1] is zone -> reactor).
alarme_sonoro  output  1  audible alarm.
isolamento  output  1  high while dampers are force-closed.
estado  output  2  FSM state code.

Behaviour:
- Reset: damper=0, alarme_sonoro=0, isolamento=0, estado=NORMAL (2'd0), persistence counter=0. Synchronous reset only; asserting rst mid-operation returns all of these to reset values on the next edge, regardless of state.
- All inputs are sampled in a register stage. Boundary i is healthy when p[i] >= p[i+1] + DIF_MIN, with p[NUM_ZONAS] = sens_pres_rea. Compare at LARG_PRES+1 bits so that p[i+1]+DIF_MIN never wraps. Values are unsigned; all-ones is simply the maximum pressure.
- violacao is the OR of unhealthy boundaries.
- Damper command: damper[i] = healthy[i] && !isolamento, registered. Latency from sensor change to damper is 2 cycles.
- Persistence counter: increments while violacao=1, saturating at PERSIST; clears to 0 on any cycle with violacao=0.
- FSM:
  - NORMAL (0): violacao -> SUSPEITA.
  - SUSPEITA (1): violacao=0 -> NORMAL. Counter reaching PERSIST -> ALARME.
  - ALARME (2): alarme_sonoro=1, isolamento=1. reconhece -> RECONHECIDO.
  - RECONHECIDO (3): alarme_sonoro=0, isolamento=1. When violacao=0 for PERSIST consecutive cycles -> NORMAL, isolamento drops on the same edge. Violation during the clear window restarts the count and does not re-sound the alarm.
- With PERSIST=1: NORMAL->SUSPEITA->ALARME takes 2 edges after the registered violation.
- reconhece in NORMAL or SUSPEITA is ignored.
- reconhece and violation clearing on the same cycle in ALARME: go to RECONHECIDO, counter starts at 0.
- alarme_sonoro and isolamento are registered outputs decoded from the next state, so they change on the same edge as estado.

Optional Feature:
VENT_HISTERESE_EN. When defined, a boundary that is currently healthy becomes unhealthy only when p[i] < p[i+1] + DIF_MIN - 1, which is 1 LSB of hysteresis, clamped at 0. Per-boundary health is held in a register. When undefined, health is purely the instantaneous compare described above, with no extra state.

Test Plan:
- Reset, then NUM_ZONAS=4 with pressures 12,9,6,3 and reactor 0, DIF_MIN=1 -> damper=4'b1111 after 2 cycles, estado=0, alarme_sonoro=0.
- Set zone 2 to 2 (boundary 1: 9 vs 2 OK; boundary 2: 2 vs 3 fails) for 3 cycles, then restore -> damper[2]=0 during the violation, estado goes 1 and back to 0, no alarm.
- Hold the zone 2 violation for PERSIST+2 cycles -> estado=2, alarme_sonoro=1, isolamento=1, damper=4'b0000.
- Pulse reconhece, then restore pressures -> estado=3, alarme off. After 8 clean cycles estado=0, isolamento=0, and 2 cycles later damper=4'b1111.
- Reactor pressure 4'hF with zone 3 at 4'hF -> boundary 3 unhealthy with no wrap false-pass; alarm after PERSIST cycles.
- Assert rst while in ALARME -> next edge: all outputs 0, estado=0.

Source files
------------

// File: rtl/sistema_ventilacao_seq.sv
// Clocked ventilation controller: pressure-cascade health check, persistence filter and 4-state alarm FSM.
// Define VENT_HISTERESE_EN to add 1 LSB of per-boundary hysteresis on the health decision.
module sistema_ventilacao_seq #(
    parameter int NUM_ZONAS = 4,
    parameter int LARG_PRES = 4,
    parameter int DIF_MIN   = 1,
    parameter int PERSIST   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ZONAS*LARG_PRES-1:0] sens_pres,
    input  logic [LARG_PRES-1:0]           sens_pres_rea,
    input  logic                           reconhece,
    output logic [NUM_ZONAS-1:0]           damper,
    output logic                           alarme_sonoro,
    output logic                           isolamento,
    output logic [1:0]                     estado
);

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        SUSPEITA    = 2'd1,
        ALARME      = 2'd2,
        RECONHECIDO = 2'd3
    } estado_t;

    localparam int                 CW         = $clog2(PERSIST + 1);
    localparam logic [CW-1:0]      PERSIST_C  = CW'(PERSIST);
    localparam logic [CW-1:0]      PERSIST_M1 = CW'(PERSIST - 1);
    localparam logic [LARG_PRES:0] DIF_W      = (LARG_PRES + 1)'(DIF_MIN);

    logic [LARG_PRES-1:0] p [NUM_ZONAS+1];
    logic [NUM_ZONAS-1:0] healthy;
    logic                 rec_q;

    // NOTE: the sample stage has no reset and keeps tracking the inputs while rst is
    // high, so the first compare after reset already sees real pressures.
    always_ff @(posedge clk) begin
        rec_q <= reconhece;
    end

`ifdef VENT_HISTERESE_EN
    logic [NUM_ZONAS-1:0] alto;
    logic [NUM_ZONAS-1:0] baixo;
    logic [NUM_ZONAS-1:0] health_d;
    logic [NUM_ZONAS-1:0] health_q;

    always_comb begin
        for (int i = 0; i < NUM_ZONAS; i++) begin
            p[i] = sens_pres[i*LARG_PRES +: LARG_PRES];
        end
        p[NUM_ZONAS] = sens_pres_rea;
    end

    for (genvar g = 0; g < NUM_ZONAS; g++) begin : g_fronteira
        logic [LARG_PRES:0] lim_alto;
        logic [LARG_PRES:0] lim_baixo;
        assign lim_alto  = {1'b0, p[g+1]} + DIF_W;
        assign lim_baixo = (lim_alto == '0) ? '0 : lim_alto - 1'b1;
        assign alto[g]   = ({1'b0, p[g]} >= lim_alto);
        assign baixo[g]  = ({1'b0, p[g]} <  lim_baixo);
        // A healthy boundary only drops once pressure falls below the lowered threshold.
        assign health_d[g] = health_q[g] ? !baixo[g] : alto[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            health_q <= alto;
        end else begin
            health_q <= health_d;
        end
    end

    assign healthy = health_q;
`else
    logic [NUM_ZONAS*LARG_PRES-1:0] pres_q;
    logic [LARG_PRES-1:0]           rea_q;

    always_ff @(posedge clk) begin
        pres_q <= sens_pres;
        rea_q  <= sens_pres_rea;
    end

    always_comb begin
        for (int i = 0; i < NUM_ZONAS; i++) begin
            p[i] = pres_q[i*LARG_PRES +: LARG_PRES];
        end
        p[NUM_ZONAS] = rea_q;
    end

    // Extra bit keeps p[i+1] + DIF_MIN from wrapping at full-scale pressure.
    for (genvar g = 0; g < NUM_ZONAS; g++) begin : g_fronteira
        assign healthy[g] = ({1'b0, p[g]} >= ({1'b0, p[g+1]} + DIF_W));
    end
`endif

    logic                 violacao;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        clr_q, clr_d;
    estado_t              est_q, est_d;
    logic                 alarme_d, isol_d;
    logic [NUM_ZONAS-1:0] damper_d;

    assign violacao = ~&healthy;

    // NOTE: combinational next-state logic uses blocking assignments with a default
    // for every output first, so no latch is inferred.
    always_comb begin
        cnt_d = '0;
        if (violacao) begin
            cnt_d = (cnt_q == PERSIST_C) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_comb begin
        est_d = est_q;
        clr_d = '0;
        unique case (est_q)
            NORMAL: begin
                if (violacao) est_d = SUSPEITA;
            end
            SUSPEITA: begin
                if (!violacao)                est_d = NORMAL;
                else if (cnt_d == PERSIST_C)  est_d = ALARME;
            end
            ALARME: begin
                if (rec_q) est_d = RECONHECIDO;
            end
            RECONHECIDO: begin
                // Any violation restarts the clear window without re-sounding the alarm.
                if (!violacao) begin
                    if (clr_q == PERSIST_M1) est_d = NORMAL;
                    else                     clr_d = clr_q + CW'(1);
                end
            end
            default: est_d = NORMAL;
        endcase
    end

    assign alarme_d = (est_d == ALARME);
    assign isol_d   = (est_d == ALARME) || (est_d == RECONHECIDO);
    assign damper_d = healthy & {NUM_ZONAS{!isol_d}};

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            est_q         <= NORMAL;
            cnt_q         <= '0;
            clr_q         <= '0;
            alarme_sonoro <= 1'b0;
            isolamento    <= 1'b0;
            damper        <= '0;
        end else begin
            est_q         <= est_d;
            cnt_q         <= cnt_d;
            clr_q         <= clr_d;
            alarme_sonoro <= alarme_d;
            isolamento    <= isol_d;
            damper        <= damper_d;
        end
    end

    assign estado = est_q;

endmodule

// File: tb/tb_sistema_ventilacao_seq.sv
// Directed self-checking bench for sistema_ventilacao_seq (default build, 4 zones, PERSIST=8).
module tb_sistema_ventilacao_seq;

    logic        clk;
    logic        rst;
    logic [15:0] sens_pres;
    logic [3:0]  sens_pres_rea;
    logic        reconhece;
    logic [3:0]  damper;
    logic        alarme_sonoro;
    logic        isolamento;
    logic [1:0]  estado;

    int tests;
    int fails;

    sistema_ventilacao_seq #(
        .NUM_ZONAS(4),
        .LARG_PRES(4),
        .DIF_MIN  (1),
        .PERSIST  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sens_pres    (sens_pres),
        .sens_pres_rea(sens_pres_rea),
        .reconhece    (reconhece),
        .damper       (damper),
        .alarme_sonoro(alarme_sonoro),
        .isolamento   (isolamento),
        .estado       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pres(input logic [3:0] z0, input logic [3:0] z1, input logic [3:0] z2,
                            input logic [3:0] z3, input logic [3:0] rea);
        sens_pres     = {z3, z2, z1, z0};
        sens_pres_rea = rea;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reconhece = 1'b0;
        set_pres(4'd12, 4'd9, 4'd6, 4'd3, 4'd0);
        tick();
        tick();
        tests++;
        if (damper !== 4'b0000 || alarme_sonoro !== 1'b0 || isolamento !== 1'b0 || estado !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: damper=%b alarme=%b isol=%b estado=%0d, required 0000 0 0 0",
                     damper, alarme_sonoro, isolamento, estado);
        end
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (damper !== 4'b1111 || estado !== 2'd0 || alarme_sonoro !== 1'b0) begin
            fails++;
            $display("FAIL healthy_cascade: damper=%b estado=%0d alarme=%b, required 1111 0 0",
                     damper, estado, alarme_sonoro);
        end
    endtask

    task automatic test_ack_ignored_normal();
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        tick();
        tick();
        tests++;
        if (estado !== 2'd0 || isolamento !== 1'b0 || damper !== 4'b1111) begin
            fails++;
            $display("FAIL ack_in_normal: estado=%0d isol=%b damper=%b, required 0 0 1111",
                     estado, isolamento, damper);
        end
    endtask

    task automatic test_transient();
        set_pres(4'd12, 4'd9, 4'd2, 4'd3, 4'd0);
        tick();
        tick();
        tests++;
        if (damper !== 4'b1011 || estado !== 2'd1) begin
            fails++;
            $display("FAIL transient_suspect: damper=%b estado=%0d, required 1011 1", damper, estado);
        end
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        set_pres(4'd12, 4'd9, 4'd6, 4'd3, 4'd0);
        tick();
        tests++;
        if (estado !== 2'd1 || alarme_sonoro !== 1'b0) begin
            fails++;
            $display("FAIL ack_in_suspect: estado=%0d alarme=%b, required 1 0", estado, alarme_sonoro);
        end
        tick();
        tests++;
        if (estado !== 2'd0 || damper !== 4'b1111 || alarme_sonoro !== 1'b0) begin
            fails++;
            $display("FAIL transient_recover: estado=%0d damper=%b alarme=%b, required 0 1111 0",
                     estado, damper, alarme_sonoro);
        end
    endtask

    task automatic test_alarm();
        set_pres(4'd12, 4'd9, 4'd2, 4'd3, 4'd0);
        repeat (8) tick();
        tests++;
        if (estado !== 2'd1 || alarme_sonoro !== 1'b0) begin
            fails++;
            $display("FAIL persist_not_yet: estado=%0d alarme=%b, required 1 0", estado, alarme_sonoro);
        end
        tick();
        tests++;
        if (estado !== 2'd2 || alarme_sonoro !== 1'b1 || isolamento !== 1'b1) begin
            fails++;
            $display("FAIL alarm_fires: estado=%0d alarme=%b isol=%b, required 2 1 1",
                     estado, alarme_sonoro, isolamento);
        end
        tick();
        tests++;
        if (estado !== 2'd2 || alarme_sonoro !== 1'b1 || isolamento !== 1'b1 || damper !== 4'b0000) begin
            fails++;
            $display("FAIL alarm_hold: estado=%0d alarme=%b isol=%b damper=%b, required 2 1 1 0000",
                     estado, alarme_sonoro, isolamento, damper);
        end
    endtask

    task automatic test_ack_clear();
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        set_pres(4'd12, 4'd9, 4'd6, 4'd3, 4'd0);
        tick();
        tests++;
        if (estado !== 2'd3 || alarme_sonoro !== 1'b0 || isolamento !== 1'b1) begin
            fails++;
            $display("FAIL ack_enter: estado=%0d alarme=%b isol=%b, required 3 0 1",
                     estado, alarme_sonoro, isolamento);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            tests++;
            if (estado !== 2'd3 || isolamento !== 1'b1 || damper !== 4'b0000) begin
                fails++;
                $display("FAIL clear_window_%0d: estado=%0d isol=%b damper=%b, required 3 1 0000",
                         i, estado, isolamento, damper);
            end
        end
        tick();
        tests++;
        if (estado !== 2'd0 || isolamento !== 1'b0 || alarme_sonoro !== 1'b0) begin
            fails++;
            $display("FAIL clear_done: estado=%0d isol=%b alarme=%b, required 0 0 0",
                     estado, isolamento, alarme_sonoro);
        end
        tick();
        tick();
        tests++;
        if (damper !== 4'b1111) begin
            fails++;
            $display("FAIL dampers_reopen: damper=%b, required 1111", damper);
        end
    endtask

    task automatic test_no_wrap();
        set_pres(4'd12, 4'd9, 4'd6, 4'hF, 4'hF);
        tick();
        tick();
        tests++;
        if (damper !== 4'b0011 || estado !== 2'd1) begin
            fails++;
            $display("FAIL full_scale_compare: damper=%b estado=%0d, required 0011 1", damper, estado);
        end
        repeat (6) tick();
        tests++;
        if (estado !== 2'd1) begin
            fails++;
            $display("FAIL full_scale_persist: estado=%0d, required 1", estado);
        end
        tick();
        tests++;
        if (estado !== 2'd2 || alarme_sonoro !== 1'b1 || isolamento !== 1'b1) begin
            fails++;
            $display("FAIL full_scale_alarm: estado=%0d alarme=%b isol=%b, required 2 1 1",
                     estado, alarme_sonoro, isolamento);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        tests++;
        if (damper !== 4'b0000 || alarme_sonoro !== 1'b0 || isolamento !== 1'b0 || estado !== 2'd0) begin
            fails++;
            $display("FAIL reset_from_alarm: damper=%b alarme=%b isol=%b estado=%0d, required 0000 0 0 0",
                     damper, alarme_sonoro, isolamento, estado);
        end
        set_pres(4'd12, 4'd9, 4'd6, 4'd3, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (damper !== 4'b1111 || estado !== 2'd0 || isolamento !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_run: damper=%b estado=%0d isol=%b, required 1111 0 0",
                     damper, estado, isolamento);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        reconhece = 1'b0;
        sens_pres = '0;
        sens_pres_rea = '0;
        test_reset();
        test_ack_ignored_normal();
        test_transient();
        test_alarm();
        test_ack_clear();
        test_no_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
